// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - state encoding, opcodes and ALU control codes for control_unit
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXEC_R    = 4'd6,
        EXEC_I    = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        HALT      = 4'd10
    } state_t;

    // Which decode rule the ALU decoder applies in the current state
    typedef enum logic [1:0] {
        CLS_ADD    = 2'd0,
        CLS_RTYPE  = 2'd1,
        CLS_IMM    = 2'd2,
        CLS_BRANCH = 2'd3
    } alu_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - funct3/funct7_5 to ALU control code and legality flag (CTRL_BNE_EN adds bne)
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output logic [3:0]  control,
    output logic        funct_ok,
    output logic        branch_ne
);

    always_comb begin
        control   = ALU_ADD;
        funct_ok  = 1'b1;
        branch_ne = 1'b0;
        case (alu_class)
            CLS_RTYPE: begin
                case (funct3)
                    3'b000:  control = funct7_5 ? ALU_SUB : ALU_ADD;
                    3'b111:  control = ALU_AND;
                    3'b110:  control = ALU_OR;
                    default: funct_ok = 1'b0;
                endcase
            end
            CLS_IMM: begin
                funct_ok = (funct3 == 3'b000);
            end
            CLS_BRANCH: begin
                control = ALU_SUB;
                case (funct3)
                    3'b000: funct_ok = 1'b1;
`ifdef CTRL_BNE_EN
                    3'b001: branch_ne = 1'b1;
`endif
                    default: funct_ok = 1'b0;
                endcase
            end
            default: control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RISC-V control FSM with retired-instruction counter (CTRL_BNE_EN enables bne)
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        zero,
    output logic        PCWrite,
    output logic        IorD,
    output logic        memRead,
    output logic        memWrite,
    output logic        IRWrite,
    output logic        memtoReg,
    output logic        regWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic        PCSource,
    output logic [3:0]  control,
    output logic        illegal,
    output logic [31:0] instr_count
);

    state_t     state;
    state_t     next_state;
    alu_class_t alu_class;
    logic [3:0] dec_control;
    logic       funct_ok;
    logic       branch_ne;
    logic       retire;

    always_comb begin
        case (state)
            EXEC_R:  alu_class = CLS_RTYPE;
            EXEC_I:  alu_class = CLS_IMM;
            BRANCH:  alu_class = CLS_BRANCH;
            default: alu_class = CLS_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_class (alu_class),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .control   (dec_control),
        .funct_ok  (funct_ok),
        .branch_ne (branch_ne)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:     next_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = MEM_ADDR;
                    OP_RTYPE:          next_state = EXEC_R;
                    OP_IMM:            next_state = EXEC_I;
                    OP_BRANCH:         next_state = BRANCH;
                    default:           next_state = HALT;
                endcase
            end
            MEM_ADDR:  next_state = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            MEM_READ:  next_state = MEM_WB;
            MEM_WB:    next_state = FETCH;
            MEM_WRITE: next_state = FETCH;
            EXEC_R:    next_state = funct_ok ? ALU_WB : HALT;
            EXEC_I:    next_state = funct_ok ? ALU_WB : HALT;
            ALU_WB:    next_state = FETCH;
            BRANCH:    next_state = funct_ok ? FETCH : HALT;
            HALT:      next_state = HALT;
            default:   next_state = FETCH;
        endcase
    end

    // Only the write-back style states finish an instruction; HALT never leaves
    assign retire = (next_state == FETCH) &&
                    ((state == MEM_WB) || (state == MEM_WRITE) ||
                     (state == ALU_WB) || (state == BRANCH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= 32'd0;
        end else if (retire) begin
            instr_count <= instr_count + 32'd1;
        end
    end

    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        IRWrite  = 1'b0;
        memtoReg = 1'b0;
        regWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSource = 1'b0;
        control  = 4'b0000;
        illegal  = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    memRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    control = ALU_ADD;
                end
                DECODE: begin
                    PCWrite  = 1'b1;
                    PCSource = 1'b1;
                    ALUSrcB  = 2'b10;
                    control  = ALU_ADD;
                end
                MEM_ADDR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    control = ALU_ADD;
                end
                MEM_READ: begin
                    memRead = 1'b1;
                    IorD    = 1'b1;
                end
                MEM_WB: begin
                    regWrite = 1'b1;
                    memtoReg = 1'b1;
                end
                MEM_WRITE: begin
                    memWrite = 1'b1;
                    IorD     = 1'b1;
                end
                EXEC_R: begin
                    ALUSrcA = 1'b1;
                    control = dec_control;
                end
                EXEC_I: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    control = dec_control;
                end
                ALU_WB: begin
                    regWrite = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA  = 1'b1;
                    PCSource = 1'b1;
                    control  = dec_control;
                    // An unsupported branch funct must not disturb the PC
                    PCWrite  = funct_ok & (branch_ne ? ~zero : zero);
                end
                HALT: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit with a per-instruction cycle-plan model
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic        zero;
    logic        PCWrite, IorD, memRead, memWrite, IRWrite, memtoReg, regWrite;
    logic        ALUSrcA, PCSource, illegal;
    logic [1:0]  ALUSrcB;
    logic [3:0]  control;
    logic [31:0] instr_count;

    control_unit dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7_5    (funct7_5),
        .zero        (zero),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .IRWrite     (IRWrite),
        .memtoReg    (memtoReg),
        .regWrite    (regWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .control     (control),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [15:0] M_ALL  = 16'hFFFF;
    localparam logic [15:0] M_NCTL = 16'hFFE1;
    localparam logic [15:0] M_NPCW = 16'h7FE1;

    typedef struct {
        logic [15:0] vec;
        logic [15:0] mask;
        logic [31:0] cnt;
        int          zdrv;
        int          instr_no;
        int          step;
    } exp_t;

    exp_t        plan[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_count = 0;
    int          instr_no = 0;

    function automatic logic [15:0] mk(input logic pcw, input logic iord, input logic mr,
                                       input logic mw, input logic irw, input logic m2r,
                                       input logic rw, input logic asa, input logic [1:0] asb,
                                       input logic pcs, input logic [3:0] ctl, input logic ill);
        return {pcw, iord, mr, mw, irw, m2r, rw, asa, asb, pcs, ctl, ill};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {PCWrite, IorD, memRead, memWrite, IRWrite, memtoReg, regWrite,
                ALUSrcA, ALUSrcB, PCSource, control, illegal};
    endfunction

    task automatic add_step(input logic [15:0] v, input logic [15:0] m, input int zd);
        exp_t e;
        e.vec = v; e.mask = m; e.cnt = model_count; e.zdrv = zd;
        e.instr_no = instr_no; e.step = plan.size();
        plan.push_back(e);
    endtask

    // Builds the expected per-cycle outputs of one instruction; returns 1 if it ends in HALT
    task automatic build_plan(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                              input logic zb, output bit halts);
        logic [3:0] ctl;
        bit         ok;
        bit         taken;
        plan.delete();
        halts = 0;
        add_step(mk(0,0,1,0,1,0,0,0,2'b01,0,4'b0010,0), M_ALL, -1);
        add_step(mk(1,0,0,0,0,0,0,0,2'b10,1,4'b0010,0), M_ALL, -1);
        if (op == 7'b0000011) begin
            add_step(mk(0,0,0,0,0,0,0,1,2'b10,0,4'b0010,0), M_ALL, -1);
            add_step(mk(0,1,1,0,0,0,0,0,2'b00,0,4'b0000,0), M_ALL, -1);
            add_step(mk(0,0,0,0,0,1,1,0,2'b00,0,4'b0000,0), M_ALL, -1);
        end else if (op == 7'b0100011) begin
            add_step(mk(0,0,0,0,0,0,0,1,2'b10,0,4'b0010,0), M_ALL, -1);
            add_step(mk(0,1,0,1,0,0,0,0,2'b00,0,4'b0000,0), M_ALL, -1);
        end else if (op == 7'b0010011) begin
            add_step(mk(0,0,0,0,0,0,0,1,2'b10,0,4'b0010,0), (f3 == 3'b000) ? M_ALL : M_NCTL, -1);
            if (f3 == 3'b000) add_step(mk(0,0,0,0,0,0,1,0,2'b00,0,4'b0000,0), M_ALL, -1);
            else halts = 1;
        end else if (op == 7'b0110011) begin
            ok = 1;
            ctl = 4'b0010;
            if (f3 == 3'b000) ctl = f75 ? 4'b0110 : 4'b0010;
            else if (f3 == 3'b111) ctl = 4'b0000;
            else if (f3 == 3'b110) ctl = 4'b0001;
            else ok = 0;
            add_step(mk(0,0,0,0,0,0,0,1,2'b00,0,ctl,0), ok ? M_ALL : M_NCTL, -1);
            if (ok) add_step(mk(0,0,0,0,0,0,1,0,2'b00,0,4'b0000,0), M_ALL, -1);
            else halts = 1;
        end else if (op == 7'b1100011) begin
            ok = (f3 == 3'b000);
            taken = zb;
`ifdef CTRL_BNE_EN
            if (f3 == 3'b001) begin
                ok = 1;
                taken = !zb;
            end
`endif
            add_step(mk(taken,0,0,0,0,0,0,1,2'b00,1,4'b0110,0), ok ? M_ALL : M_NPCW, int'(zb));
            if (!ok) halts = 1;
        end else begin
            halts = 1;
        end
        if (halts) begin
            for (int i = 0; i < 11; i++) add_step(mk(0,0,0,0,0,0,0,0,2'b00,0,4'b0000,1), M_ALL, -1);
        end
    endtask

    task automatic do_reset(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            zero = 1'($urandom);
            model_count = 0;
            e.vec = 16'h0000; e.mask = M_ALL; e.cnt = 0; e.zdrv = -1;
            e.instr_no = -1; e.step = i;
            sb.push_back(e);
        end
    endtask

    // abort_at < 0 runs to completion; otherwise reset is asserted after that many cycles
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic zb, input int abort_at);
        bit halts;
        int n;
        instr_no++;
        build_plan(op, f3, f75, zb, halts);
        n = (abort_at >= 0 && abort_at < plan.size()) ? abort_at : plan.size();
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            opcode = op; funct3 = f3; funct7_5 = f75;
            zero = (plan[i].zdrv >= 0) ? 1'(plan[i].zdrv) : 1'($urandom);
            sb.push_back(plan[i]);
        end
        if (n < plan.size() || halts) do_reset(2);
        else model_count = model_count + 32'd1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] act;
            e = sb.pop_front();
            act = dut_vec();
            checks++;
            if ((((act ^ e.vec) & e.mask) != 16'h0) || (instr_count !== e.cnt)) begin
                errors++;
                $display("FAIL instr%0d_step%0d: outputs got %h cnt %0d, expected %h (mask %h) cnt %0d",
                         e.instr_no, e.step, act, instr_count, e.vec, e.mask, e.cnt);
            end
        end
    end

    initial begin
        logic [6:0] ops [5];
        int         k;
        int         guard;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0010011;
        ops[3] = 7'b0110011; ops[4] = 7'b1100011;
        reset = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = 1'b0;
        do_reset(2);

        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, -1);
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, -1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, -1);
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, -1);
        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, -1);
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, -1);
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, -1);
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, -1);
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, -1);
        run_instr(7'b0110011, 3'b010, 1'b0, 1'b0, -1);
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, -1);
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0, -1);
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b1, -1);
        run_instr(7'b0010011, 3'b011, 1'b0, 1'b0, -1);
        run_instr(7'b0010011, 3'b000, 1'b0, 1'b0, -1);
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 3);
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, -1);

        for (int t = 0; t < 80; t++) begin
            logic [6:0] op;
            logic [2:0] f3;
            logic       f75;
            int         ab;
            k = $urandom_range(0, 9);
            f75 = 1'b0;
            f3 = 3'b000;
            case (k)
                0: begin op = 7'b0000011; f3 = 3'b010; end
                1: begin op = 7'b0100011; f3 = 3'b010; end
                2: op = 7'b0010011;
                3: op = 7'b0110011;
                4: begin op = 7'b0110011; f75 = 1'b1; end
                5: begin op = 7'b0110011; f3 = 3'b111; end
                6: begin op = 7'b0110011; f3 = 3'b110; end
                7: op = 7'b1100011;
                8: op = 7'($urandom);
                default: begin
                    op = ops[$urandom_range(0, 4)];
                    f3 = 3'($urandom);
                    f75 = 1'($urandom);
                end
            endcase
            ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : -1;
            run_instr(op, f3, f75, 1'($urandom), ab);
        end

        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
